// File: rtl/dma_engine_if.sv
// Bus side of the nano-z80 DMA initiator: BUSREQ/BUSACK handshake plus Z80-style strobes.
// master = DMA engine, slave = CPU/bus fabric.
interface dma_engine_if;
  logic        busreq_n_o;
  logic        busack_n_i;
  logic        bus_oe_o;
  logic [15:0] addr_o;
  logic [7:0]  data_o;
  logic [7:0]  data_i;
  logic        mreq_n_o;
  logic        ioreq_n_o;
  logic        rd_n_o;
  logic        wr_n_o;
  logic        wait_n_i;

  modport master (
    output busreq_n_o, bus_oe_o, addr_o, data_o, mreq_n_o, ioreq_n_o, rd_n_o, wr_n_o,
    input  busack_n_i, data_i, wait_n_i
  );

  modport slave (
    input  busreq_n_o, bus_oe_o, addr_o, data_o, mreq_n_o, ioreq_n_o, rd_n_o, wr_n_o,
    output busack_n_i, data_i, wait_n_i
  );
endinterface

// File: rtl/dma_engine.sv
// Z80-bus DMA initiator: takes the bus via BUSREQ/BUSACK and copies LEN bytes from SRC to DST.
// Define DMA_WAIT_EN to let wait_n_i stretch RD2/WR2; otherwise every byte takes 4 cycles.
module dma_engine (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         reg_cs_i,
  input  logic         reg_wr_n_i,
  input  logic [2:0]   reg_addr_i,
  input  logic [7:0]   reg_data_i,
  output logic [7:0]   reg_data_o,
  output logic         irq_o,
  dma_engine_if.master bus
);

  typedef enum logic [2:0] {StIdle, StReq, StRd1, StRd2, StWr1, StWr2} state_e;

  state_e      state_q;
  logic [15:0] src_q, dst_q, len_q;
  logic        src_io_q, dst_io_q, irq_en_q;
  logic        done_q, busy_q, abort_q;
  logic        busreq_n_q, bus_oe_q, mreq_n_q, ioreq_n_q, rd_n_q, wr_n_q, irq_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;

  logic        reg_we, abort_wr, stall;
  logic [15:0] src_nxt, dst_nxt, len_nxt;

`ifdef DMA_WAIT_EN
  assign stall = ~bus.wait_n_i;
`else
  logic unused_wait_n;
  assign unused_wait_n = bus.wait_n_i;
  assign stall         = 1'b0;
`endif

  assign reg_we   = reg_cs_i & ~reg_wr_n_i;
  assign abort_wr = reg_we & (reg_addr_i == 3'd6) & reg_data_i[4];
  assign src_nxt  = src_io_q ? src_q : src_q + 16'd1;
  assign dst_nxt  = dst_io_q ? dst_q : dst_q + 16'd1;
  assign len_nxt  = len_q - 16'd1;

  assign bus.busreq_n_o = busreq_n_q;
  assign bus.bus_oe_o   = bus_oe_q;
  assign bus.addr_o     = addr_q;
  assign bus.data_o     = data_q;
  assign bus.mreq_n_o   = mreq_n_q;
  assign bus.ioreq_n_o  = ioreq_n_q;
  assign bus.rd_n_o     = rd_n_q;
  assign bus.wr_n_o     = wr_n_q;
  assign irq_o          = irq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      src_q      <= 16'h0000;
      dst_q      <= 16'h0000;
      len_q      <= 16'h0000;
      src_io_q   <= 1'b0;
      dst_io_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      busreq_n_q <= 1'b1;
      bus_oe_q   <= 1'b0;
      mreq_n_q   <= 1'b1;
      ioreq_n_q  <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      addr_q     <= 16'h0000;
      data_q     <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= done_q & irq_en_q;

      // Register window; FSM assignments below take priority on the same edge.
      if (reg_we) begin
        case (reg_addr_i)
          3'd0: if (!busy_q) src_q[7:0]  <= reg_data_i;
          3'd1: if (!busy_q) src_q[15:8] <= reg_data_i;
          3'd2: if (!busy_q) dst_q[7:0]  <= reg_data_i;
          3'd3: if (!busy_q) dst_q[15:8] <= reg_data_i;
          3'd4: if (!busy_q) len_q[7:0]  <= reg_data_i;
          3'd5: if (!busy_q) len_q[15:8] <= reg_data_i;
          3'd6: begin
            src_io_q <= reg_data_i[1];
            dst_io_q <= reg_data_i[2];
            irq_en_q <= reg_data_i[3];
            if (reg_data_i[0] && !busy_q) begin
              if (len_q == 16'h0000) begin
                done_q <= 1'b1;
              end else begin
                done_q     <= 1'b0;
                busy_q     <= 1'b1;
                state_q    <= StReq;
                busreq_n_q <= 1'b0;
              end
            end
            if (reg_data_i[4] && busy_q) abort_q <= 1'b1;
          end
          3'd7: if (reg_data_i[7]) done_q <= 1'b0;
          default: ;
        endcase
      end

      case (state_q)
        StReq: begin
          if (abort_q || abort_wr) begin
            state_q    <= StIdle;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            busreq_n_q <= 1'b1;
          end else if (!bus.busack_n_i) begin
            state_q   <= StRd1;
            bus_oe_q  <= 1'b1;
            addr_q    <= src_q;
            mreq_n_q  <= src_io_q;
            ioreq_n_q <= ~src_io_q;
            rd_n_q    <= 1'b0;
          end
        end
        StRd1: state_q <= StRd2;
        StRd2: begin
          if (!stall) begin
            state_q   <= StWr1;
            addr_q    <= dst_q;
            data_q    <= bus.data_i;
            mreq_n_q  <= dst_io_q;
            ioreq_n_q <= ~dst_io_q;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b0;
          end
        end
        StWr1: state_q <= StWr2;
        StWr2: begin
          if (!stall) begin
            src_q  <= src_nxt;
            dst_q  <= dst_nxt;
            len_q  <= len_nxt;
            wr_n_q <= 1'b1;
            if (len_nxt == 16'h0000 || abort_q) begin
              state_q    <= StIdle;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              abort_q    <= 1'b0;
              busreq_n_q <= 1'b1;
              bus_oe_q   <= 1'b0;
              mreq_n_q   <= 1'b1;
              ioreq_n_q  <= 1'b1;
            end else begin
              // Back-to-back: next read starts on the same edge the write ends.
              state_q   <= StRd1;
              addr_q    <= src_nxt;
              mreq_n_q  <= src_io_q;
              ioreq_n_q <= ~src_io_q;
              rd_n_q    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_data_o = 8'h00;
    case (reg_addr_i)
      3'd0:    reg_data_o = src_q[7:0];
      3'd1:    reg_data_o = src_q[15:8];
      3'd2:    reg_data_o = dst_q[7:0];
      3'd3:    reg_data_o = dst_q[15:8];
      3'd4:    reg_data_o = len_q[7:0];
      3'd5:    reg_data_o = len_q[15:8];
      3'd6:    reg_data_o = {done_q, 3'b000, irq_en_q, dst_io_q, src_io_q, busy_q};
      3'd7:    reg_data_o = {done_q, 6'b000000, busy_q};
      default: reg_data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: register table, directed transfers and random copies vs a byte-level model.
module tb_dma_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       reg_cs, reg_wr_n;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       irq;

  dma_engine_if bus ();

  dma_engine dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reg_cs_i   (reg_cs),
    .reg_wr_n_i (reg_wr_n),
    .reg_addr_i (reg_addr),
    .reg_data_i (reg_wdata),
    .reg_data_o (reg_rdata),
    .irq_o      (irq),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        mreq_n;
    logic        ioreq_n;
    logic [15:0] a;
    logic [7:0]  d;
  } acc_t;

  typedef struct {
    bit         wr;
    logic [2:0] a;
    logic [7:0] wd;
    logic [7:0] exp;
  } reg_vec_t;

  // Device memory/IO spaces (driven by DUT cycles) and the model's own copies.
  logic [7:0] dmem [65536];
  logic [7:0] dio  [65536];
  logic [7:0] mmem [65536];
  logic [7:0] mio  [65536];

  int n_vec = 0;
  int n_mis = 0;

  always_comb begin
    bus.data_i = 8'h00;
    if (!bus.rd_n_o) bus.data_i = !bus.ioreq_n_o ? dio[bus.addr_o] : dmem[bus.addr_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; reg_wr_n = 1'b0; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_cs = 1'b0; reg_wr_n = 1'b1;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic reg_read16(input logic [2:0] a, output logic [15:0] w);
    logic [7:0] lo, hi;
    reg_read(a, lo);
    reg_read(a + 3'd1, hi);
    w = {hi, lo};
  endtask

  function automatic acc_t mk_acc(input logic wr, input logic io, input logic [15:0] a,
                                  input logic [7:0] d);
    acc_t r;
    r.wr = wr; r.mreq_n = io; r.ioreq_n = ~io; r.a = a; r.d = d;
    return r;
  endfunction

  // Full transfer: model predicts the byte sequence, bench acts as CPU + bus and logs accesses.
  task automatic run_xfer(input string name, input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input logic [7:0] ctrl, input int ack_delay,
                          input int wait_cyc, input int abort_at);
    acc_t        exp_q[$];
    acc_t        log_q[$];
    acc_t        cur;
    logic [17:0] key, prev_key;
    logic [15:0] sa, da, w;
    logic [7:0]  v, rb;
    int          nbytes, cyc, rd_run, wr_run, rd_max, wr_max, wait_left, extra, budget;
    bit          sio, dio_m, abort_clr, abort_sent, wait_started;

    sio   = ctrl[1];
    dio_m = ctrl[2];
    nbytes = int'(len);
    if (abort_at > 0 && abort_at / 4 + 1 < nbytes) nbytes = abort_at / 4 + 1;
    sa = src;
    da = dst;
    for (int i = 0; i < nbytes; i++) begin
      v = sio ? mio[sa] : mmem[sa];
      exp_q.push_back(mk_acc(1'b0, sio, sa, v));
      exp_q.push_back(mk_acc(1'b1, dio_m, da, v));
      if (dio_m) mio[da] = v; else mmem[da] = v;
      if (!sio) sa = sa + 16'd1;
      if (!dio_m) da = da + 16'd1;
    end
    extra = 0;
`ifdef DMA_WAIT_EN
    extra = wait_cyc;
`endif

    reg_write(3'd0, src[7:0]);
    reg_write(3'd1, src[15:8]);
    reg_write(3'd2, dst[7:0]);
    reg_write(3'd3, dst[15:8]);
    reg_write(3'd4, len[7:0]);
    reg_write(3'd5, len[15:8]);
    reg_write(3'd6, ctrl | 8'h01);
    check({name, " busreq after start"}, 32'(bus.busreq_n_o), 32'd0);
    reg_read(3'd7, rb);
    check({name, " status busy"}, 32'(rb), 32'h01);

    repeat (ack_delay) @(negedge clk);
    bus.busack_n_i = 1'b0;

    cyc = 0; rd_run = 0; wr_run = 0; rd_max = 0; wr_max = 0; wait_left = 0; budget = 0;
    abort_clr = 0; abort_sent = 0; wait_started = 0;
    prev_key = '1;
    forever begin
      @(negedge clk);
      if (abort_clr) begin reg_cs = 1'b0; reg_wr_n = 1'b1; abort_clr = 0; end
      if (bus.busreq_n_o) break;
      budget++;
      if (budget > 300) begin
        n_vec++; n_mis++;
        $display("FAIL %s timeout: busreq_n still 0 after %0d cycles, want release", name, budget);
        break;
      end
      if (bus.bus_oe_o) cyc++;
      rd_run = bus.rd_n_o ? 0 : rd_run + 1;
      wr_run = bus.wr_n_o ? 0 : wr_run + 1;
      if (rd_run > rd_max) rd_max = rd_run;
      if (wr_run > wr_max) wr_max = wr_run;
      key = {bus.rd_n_o, bus.wr_n_o, bus.addr_o};
      if ((!bus.rd_n_o || !bus.wr_n_o) && key != prev_key) begin
        cur.wr = ~bus.wr_n_o; cur.mreq_n = bus.mreq_n_o; cur.ioreq_n = bus.ioreq_n_o;
        cur.a = bus.addr_o; cur.d = bus.wr_n_o ? bus.data_i : bus.data_o;
        log_q.push_back(cur);
      end
      prev_key = key;
      if (!bus.wr_n_o) begin
        if (!bus.ioreq_n_o) dio[bus.addr_o] = bus.data_o;
        else if (!bus.mreq_n_o) dmem[bus.addr_o] = bus.data_o;
      end
      if (wait_cyc > 0 && cyc == 2 && !wait_started) begin
        bus.wait_n_i = 1'b0; wait_left = wait_cyc; wait_started = 1;
      end else if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) bus.wait_n_i = 1'b1;
      end
      if (abort_at > 0 && cyc == abort_at && !abort_sent) begin
        reg_cs = 1'b1; reg_wr_n = 1'b0; reg_addr = 3'd6;
        reg_wdata = (ctrl & 8'h0E) | 8'h10;
        abort_clr = 1; abort_sent = 1;
      end
    end
    bus.busack_n_i = 1'b1;
    bus.wait_n_i   = 1'b1;
    reg_cs = 1'b0; reg_wr_n = 1'b1;

    check({name, " bus cycles"}, 32'(cyc), 32'(4 * nbytes + extra));
    check({name, " rd_n low run"}, 32'(rd_max), 32'(2 + extra));
    check({name, " wr_n low run"}, 32'(wr_max), 32'd2);
    check({name, " access count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s access %0d", name, i), 32'(log_q[i]), 32'(exp_q[i]));
    if (ctrl[3]) begin
      check({name, " irq lags done"}, 32'(irq), 32'd0);
      @(negedge clk);
      check({name, " irq set"}, 32'(irq), 32'd1);
    end
    reg_read(3'd7, rb);
    check({name, " status done"}, 32'(rb), 32'h80);
    reg_read16(3'd4, w);
    check({name, " final LEN"}, 32'(w), 32'(len - 16'(nbytes)));
    reg_read16(3'd0, w);
    check({name, " final SRC"}, 32'(w), 32'(sa));
    reg_read16(3'd2, w);
    check({name, " final DST"}, 32'(w), 32'(da));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reg_vec_t    tbl [17];
    logic [7:0]  rb;
    logic [15:0] w;

    tbl[0]  = '{0, 3'd0, 8'h00, 8'h00};
    tbl[1]  = '{0, 3'd1, 8'h00, 8'h00};
    tbl[2]  = '{0, 3'd2, 8'h00, 8'h00};
    tbl[3]  = '{0, 3'd3, 8'h00, 8'h00};
    tbl[4]  = '{0, 3'd4, 8'h00, 8'h00};
    tbl[5]  = '{0, 3'd5, 8'h00, 8'h00};
    tbl[6]  = '{0, 3'd6, 8'h00, 8'h00};
    tbl[7]  = '{0, 3'd7, 8'h00, 8'h00};
    tbl[8]  = '{1, 3'd0, 8'h34, 8'h34};
    tbl[9]  = '{1, 3'd1, 8'h12, 8'h12};
    tbl[10] = '{1, 3'd2, 8'hCD, 8'hCD};
    tbl[11] = '{1, 3'd3, 8'hAB, 8'hAB};
    tbl[12] = '{1, 3'd4, 8'h05, 8'h05};
    tbl[13] = '{1, 3'd5, 8'h00, 8'h00};
    tbl[14] = '{1, 3'd6, 8'h0E, 8'h0E};
    tbl[15] = '{1, 3'd6, 8'h00, 8'h00};
    tbl[16] = '{1, 3'd7, 8'h80, 8'h00};

    for (int i = 0; i < 65536; i++) begin
      dmem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      dio[i]  = 8'(i) + 8'(i >> 8) + 8'hC3;
      mmem[i] = dmem[i];
      mio[i]  = dio[i];
    end

    rst = 1'b1; reg_cs = 1'b0; reg_wr_n = 1'b1; reg_addr = 3'd0; reg_wdata = 8'h00;
    bus.busack_n_i = 1'b1; bus.wait_n_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busreq_n", 32'(bus.busreq_n_o), 32'd1);
    check("reset bus_oe", 32'(bus.bus_oe_o), 32'd0);
    check("reset strobes", 32'({bus.mreq_n_o, bus.ioreq_n_o, bus.rd_n_o, bus.wr_n_o}), 32'hF);
    check("reset addr", 32'(bus.addr_o), 32'h0000);
    check("reset data_o", 32'(bus.data_o), 32'h00);
    check("reset irq", 32'(irq), 32'd0);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) reg_write(tbl[i].a, tbl[i].wd);
      reg_read(tbl[i].a, rb);
      check($sformatf("regvec %0d", i), 32'(rb), 32'(tbl[i].exp));
    end

    // Memory copy with delayed grant.
    dmem[16'h8000] = 8'h11; dmem[16'h8001] = 8'h22; dmem[16'h8002] = 8'h33;
    mmem[16'h8000] = 8'h11; mmem[16'h8001] = 8'h22; mmem[16'h8002] = 8'h33;
    run_xfer("memcopy", 16'h8000, 16'h9000, 16'd3, 8'h00, 2, 0, 0);
    check("memcopy byte0", 32'(dmem[16'h9000]), 32'h11);
    check("memcopy byte1", 32'(dmem[16'h9001]), 32'h22);
    check("memcopy byte2", 32'(dmem[16'h9002]), 32'h33);

    // LEN=0 start: done without touching the bus.
    reg_write(3'd7, 8'h80);
    reg_read(3'd7, rb);
    check("len0 done cleared", 32'(rb), 32'h00);
    reg_write(3'd4, 8'h00);
    reg_write(3'd5, 8'h00);
    reg_write(3'd6, 8'h01);
    check("len0 busreq_n", 32'(bus.busreq_n_o), 32'd1);
    reg_read(3'd7, rb);
    check("len0 done", 32'(rb), 32'h80);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("len0 bus idle",
            32'({bus.busreq_n_o, bus.bus_oe_o, bus.rd_n_o, bus.wr_n_o}), 32'b1011);
    end

    run_xfer("io2mem wrap", 16'h0010, 16'hFFFF, 16'd2, 8'h02, 0, 0, 0);
    run_xfer("abort rd2", 16'h4000, 16'h4100, 16'd4, 8'h00, 1, 0, 2);

    run_xfer("irq", 16'h5000, 16'h5100, 16'd1, 8'h08, 1, 0, 0);
    reg_write(3'd7, 8'h80);
    check("irq held one cycle after clear", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq cleared", 32'(irq), 32'd0);
    reg_write(3'd6, 8'h00);

    run_xfer("wait rd2", 16'h3000, 16'h3100, 16'd2, 8'h00, 1, 3, 0);

    // Abort while still requesting; busy blocks counter writes.
    reg_write(3'd0, 8'h34); reg_write(3'd1, 8'h12);
    reg_write(3'd2, 8'h78); reg_write(3'd3, 8'h56);
    reg_write(3'd4, 8'h05); reg_write(3'd5, 8'h00);
    reg_write(3'd6, 8'h01);
    check("req busreq_n", 32'(bus.busreq_n_o), 32'd0);
    reg_write(3'd4, 8'h77);
    reg_read(3'd4, rb);
    check("busy write ignored", 32'(rb), 32'h05);
    reg_write(3'd6, 8'h10);
    check("req abort busreq_n", 32'(bus.busreq_n_o), 32'd1);
    reg_read(3'd7, rb);
    check("req abort done", 32'(rb), 32'h80);
    reg_read16(3'd4, w);
    check("req abort LEN", 32'(w), 32'h0005);

    for (int i = 0; i < 20; i++)
      run_xfer($sformatf("rand%0d", i), 16'($urandom), 16'($urandom),
               16'($urandom_range(1, 6)), 8'($urandom_range(0, 3) << 1),
               int'($urandom_range(0, 3)), 0, 0);

    // Reset mid-transfer releases the bus at once.
    reg_write(3'd0, 8'h00); reg_write(3'd1, 8'h01);
    reg_write(3'd2, 8'h00); reg_write(3'd3, 8'h02);
    reg_write(3'd4, 8'h10); reg_write(3'd5, 8'h00);
    reg_write(3'd6, 8'h01);
    bus.busack_n_i = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-reset bus_oe", 32'(bus.bus_oe_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset busreq_n", 32'(bus.busreq_n_o), 32'd1);
    check("midreset bus_oe", 32'(bus.bus_oe_o), 32'd0);
    check("midreset strobes",
          32'({bus.mreq_n_o, bus.ioreq_n_o, bus.rd_n_o, bus.wr_n_o}), 32'hF);
    check("midreset addr", 32'(bus.addr_o), 32'h0000);
    @(negedge clk);
    bus.busack_n_i = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    reg_read(3'd4, rb);
    check("midreset LEN", 32'(rb), 32'h00);
    reg_read(3'd7, rb);
    check("midreset status", 32'(rb), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
